// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage external access sequencer:
// control-word bit positions, target encodings and FSM states.
package mem_ctrl_pkg;

    localparam int CTRL_RD   = 6;
    localparam int CTRL_KSEL = 5;
    localparam int CTRL_PACK = 3;
    localparam int CTRL_WR   = 0;

    localparam logic [1:0] SEL_PIXEL   = 2'b00;
    localparam logic [1:0] SEL_KERNEL  = 2'b01;
    localparam logic [1:0] SEL_PICTURE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    // Writes always land in picture RAM; reads pick a ROM with the select bit.
    function automatic logic [1:0] target_sel(input logic [6:0] ctrl);
        if (ctrl[CTRL_WR])
            return SEL_PICTURE;
        return ctrl[CTRL_KSEL] ? SEL_KERNEL : SEL_PIXEL;
    endfunction

endpackage

// File: rtl/mem_byte_packer.sv
// 32-bit assembly register filled one byte lane at a time, with a
// synchronous clear at the start of every access.
module mem_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [3:0]  lane_we,
    input  logic [7:0]  din,
    output logic [31:0] dout
);

    // NOTE: sequential state is written with <= only, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (clr) begin
            dout <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i])
                    dout[8*i +: 8] <= din;
            end
        end
    end

endmodule

// File: rtl/mem_ext_access.sv
// MEM-stage sequencer for kernel/pixel reads and picture saves: runs byte
// handshakes on the external memories and stalls the pipeline meanwhile.
module mem_ext_access
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_m,
    input  logic [6:0]        ctrl_m,
    input  logic [31:0]       addr_m,
    input  logic [31:0]       wdata_m,
    output logic              stall_m,
    output logic [31:0]       rdata_m,
    output logic              rdata_valid_m,
    output logic              err_m,
    output logic              ext_req,
    output logic              ext_we,
    output logic [1:0]        ext_sel,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    input  logic [7:0]        ext_rdata,
    input  logic              ext_ack
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [6:0]         ctrl_q;
    logic [ADDR_W-1:0]  base_q;
    logic [7:0]         wdata_q;
    logic [1:0]         beat_q;
    logic [TIMER_W-1:0] timer_q;
    logic               err_q;
    logic [31:0]        rdata_q;
    logic [31:0]        pack_q;
    logic [31:0]        rdata_merged;
    logic               op_active, start, is_read;
    logic               beat_done, last_beat, timed_out;
    logic [3:0]         lane_we;
    logic               unused_bits;

    assign unused_bits = ^{addr_m[31:ADDR_W], wdata_m[31:8], ctrl_q[4], ctrl_q[2:1]};

    assign op_active = valid_m & (ctrl_m[CTRL_RD] | ctrl_m[CTRL_WR]);
    assign is_read   = ctrl_q[CTRL_RD] & ~ctrl_q[CTRL_WR];
    assign beat_done = (state_q == ACCESS) & ext_ack;
    assign last_beat = (beat_q == ((is_read & ctrl_q[CTRL_PACK]) ? 2'd3 : 2'd0));
    assign timed_out = (state_q == ACCESS) & ~ext_ack & (timer_q == TIMER_W'(TIMEOUT - 1));
    assign lane_we   = (beat_done & is_read) ? (4'b0001 << beat_q) : 4'b0000;

    mem_byte_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .lane_we (lane_we),
        .din     (ext_rdata),
        .dout    (pack_q)
    );

    // The final byte is merged in directly so rdata_m is complete in DONE.
    always_comb begin
        rdata_merged = pack_q;
        rdata_merged[8*beat_q +: 8] = ext_rdata;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        stall_m       = 1'b0;
        ext_req       = 1'b0;
        ext_we        = 1'b0;
        ext_sel       = SEL_PIXEL;
        ext_addr      = '0;
        ext_wdata     = '0;
        rdata_valid_m = 1'b0;
        err_m         = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_active) begin
                    stall_m = 1'b1;
                    start   = 1'b1;
                    state_d = (ctrl_m[CTRL_RD] & ctrl_m[CTRL_WR]) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall_m   = 1'b1;
                ext_req   = 1'b1;
                ext_we    = ctrl_q[CTRL_WR];
                ext_sel   = target_sel(ctrl_q);
                ext_addr  = base_q + ADDR_W'(beat_q);
                ext_wdata = ctrl_q[CTRL_WR] ? wdata_q : 8'h00;
                if ((beat_done & last_beat) | timed_out)
                    state_d = DONE;
            end
            DONE: begin
                rdata_valid_m = is_read & ~err_q;
                err_m         = err_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                ctrl_q  <= ctrl_m;
                base_q  <= addr_m[ADDR_W-1:0];
                wdata_q <= wdata_m[7:0];
                beat_q  <= '0;
                timer_q <= '0;
                err_q   <= ctrl_m[CTRL_RD] & ctrl_m[CTRL_WR];
            end else if (beat_done) begin
                beat_q  <= beat_q + 2'd1;
                timer_q <= '0;
                if (is_read & last_beat)
                    rdata_q <= rdata_merged;
            end else if (timed_out) begin
                err_q <= 1'b1;
                if (is_read)
                    rdata_q <= '0;
            end else if (state_q == ACCESS) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
        end
    end

    assign rdata_m = rdata_q;

endmodule

// File: tb/tb_mem_ext_access.sv
// Self-checking bench for mem_ext_access: directed vector table, reset
// corner case, then randomized operations against a transaction-level model.
module tb_mem_ext_access;

    localparam int ADDR_W  = 18;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_m;
    logic [6:0]        ctrl_m;
    logic [31:0]       addr_m;
    logic [31:0]       wdata_m;
    logic              stall_m;
    logic [31:0]       rdata_m;
    logic              rdata_valid_m;
    logic              err_m;
    logic              ext_req;
    logic              ext_we;
    logic [1:0]        ext_sel;
    logic [ADDR_W-1:0] ext_addr;
    logic [7:0]        ext_wdata;
    logic [7:0]        ext_rdata;
    logic              ext_ack;

    always #5 clk = ~clk;

    mem_ext_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_m       (valid_m),
        .ctrl_m        (ctrl_m),
        .addr_m        (addr_m),
        .wdata_m       (wdata_m),
        .stall_m       (stall_m),
        .rdata_m       (rdata_m),
        .rdata_valid_m (rdata_valid_m),
        .err_m         (err_m),
        .ext_req       (ext_req),
        .ext_we        (ext_we),
        .ext_sel       (ext_sel),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_rdata     (ext_rdata),
        .ext_ack       (ext_ack)
    );

    typedef struct {
        logic        valid;
        logic [6:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_valid;
        logic        exp_err;
        int          exp_beats;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  mem_img [logic [19:0]];
    logic [31:0] model_rdata;

    int          obs_stall, obs_valid, obs_err, obs_attr_bad, obs_hung;
    logic [31:0] obs_rdata;
    logic [17:0] obs_addrs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] mem_rd(input logic [1:0] sel, input logic [17:0] a);
        logic [19:0] k;
        k = {sel, a};
        if (mem_img.exists(k)) return mem_img[k];
        return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'({6'd0, sel} * 8'h5B) ^ 8'h3C;
    endfunction

    function automatic logic [1:0] sel_of(input logic [6:0] c);
        if (c[0]) return 2'b10;
        return c[5] ? 2'b01 : 2'b00;
    endfunction

    // Transaction-level expectation derived from the access rules.
    task automatic model(input logic v, input logic [6:0] c, input logic [31:0] a, input int waits,
                         output int stall, output logic [31:0] rd, output logic vld,
                         output logic er, output int nb);
        int beats;
        stall = 0; rd = model_rdata; vld = 1'b0; er = 1'b0; nb = 0;
        if (!(v && (c[6] || c[0]))) return;
        if (c[6] && c[0]) begin
            stall = 1; er = 1'b1;
            return;
        end
        beats = (c[6] && c[3]) ? 4 : 1;
        if (waits >= TIMEOUT) begin
            stall = 1 + TIMEOUT; er = 1'b1;
            if (c[6]) rd = 32'h0;
            return;
        end
        stall = 1 + beats * (waits + 1);
        nb = beats;
        if (c[6]) begin
            rd = 32'h0;
            for (int i = 0; i < beats; i++)
                rd = rd | (32'(mem_rd(sel_of(c), 18'(a[17:0] + 18'(i)))) << (8 * i));
            vld = 1'b1;
        end
    endtask

    // Drives one instruction until the pipeline is released, acting as the
    // external memory with a fixed number of wait cycles per beat.
    task automatic run_op(input logic v, input logic [6:0] c, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input bit scramble);
        int  waitc;
        bit  fin;
        logic [1:0] xsel;
        xsel = sel_of(c);
        obs_stall = 0; obs_valid = 0; obs_err = 0; obs_attr_bad = 0; obs_hung = 0;
        obs_addrs.delete();
        waitc = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0 || !scramble) begin
                valid_m = v; ctrl_m = c; addr_m = a; wdata_m = wd;
            end else begin
                valid_m = 1'($urandom); ctrl_m = 7'($urandom);
                addr_m = $urandom; wdata_m = $urandom;
            end
            #1;
            if (ext_req) begin
                ext_ack   = (waitc >= waits);
                ext_rdata = mem_rd(xsel, ext_addr);
                if (ext_sel !== xsel || ext_we !== c[0] || (c[0] && ext_wdata !== wd[7:0]))
                    obs_attr_bad++;
            end else begin
                ext_ack   = 1'($urandom);
                ext_rdata = 8'($urandom);
            end
            #1;
            if (stall_m) obs_stall++;
            if (rdata_valid_m) obs_valid++;
            if (err_m) obs_err++;
            if (ext_req && ext_ack) begin
                obs_addrs.push_back(ext_addr);
                waitc = 0;
            end else if (ext_req) begin
                waitc++;
            end
            if (!stall_m) begin
                fin = 1'b1;
                obs_rdata = rdata_m;
            end
        end
        if (!fin) obs_hung = 1;
        @(negedge clk);
        valid_m = 1'b0; ctrl_m = '0; ext_ack = 1'b0;
        #2;
        if (stall_m) obs_stall++;
        if (rdata_valid_m) obs_valid++;
        if (err_m) obs_err++;
    endtask

    task automatic run_and_check(input string nm, input logic v, input logic [6:0] c,
                                 input logic [31:0] a, input logic [31:0] wd, input int waits,
                                 input bit scramble, input int x_stall, input logic [31:0] x_rdata,
                                 input logic x_valid, input logic x_err, input int x_beats);
        run_op(v, c, a, wd, waits, scramble);
        check({nm, " released"}, 32'(obs_hung), 32'd0);
        check({nm, " stall_cycles"}, 32'(obs_stall), 32'(x_stall));
        check({nm, " rdata"}, obs_rdata, x_rdata);
        check({nm, " valid_pulses"}, 32'(obs_valid), 32'(x_valid));
        check({nm, " err_pulses"}, 32'(obs_err), 32'(x_err));
        check({nm, " beat_attrs_bad"}, 32'(obs_attr_bad), 32'd0);
        check({nm, " beats"}, 32'(obs_addrs.size()), 32'(x_beats));
        for (int i = 0; i < obs_addrs.size() && i < x_beats; i++)
            check($sformatf("%s beat%0d_addr", nm, i), 32'(obs_addrs[i]), 32'(18'(a[17:0] + 18'(i))));
        model_rdata = x_rdata;
    endtask

    initial begin
        vec_t tbl [9];
        int          m_stall, m_beats;
        logic [31:0] m_rd;
        logic        m_vld, m_er;
        logic [6:0]  c;
        logic [31:0] a;
        logic        v;
        int          w;

        mem_img[{2'b00, 18'h00100}] = 8'h11;
        mem_img[{2'b00, 18'h00101}] = 8'h22;
        mem_img[{2'b00, 18'h00102}] = 8'h33;
        mem_img[{2'b00, 18'h00103}] = 8'h44;
        mem_img[{2'b01, 18'h3FFFF}] = 8'hA5;
        mem_img[{2'b00, 18'h3FFFE}] = 8'h01;
        mem_img[{2'b00, 18'h3FFFF}] = 8'h02;
        mem_img[{2'b00, 18'h00000}] = 8'h03;
        mem_img[{2'b00, 18'h00001}] = 8'h04;
        mem_img[{2'b01, 18'h00055}] = 8'h5C;

        //         valid ctrl        addr          wdata         waits stall rdata          vld   err   beats
        tbl[0] = '{1'b1, 7'b1001110, 32'h00000100, 32'h0,        0,    5,    32'h44332211, 1'b1, 1'b0, 4};
        tbl[1] = '{1'b1, 7'b1100010, 32'h0003FFFF, 32'h0,        2,    4,    32'h000000A5, 1'b1, 1'b0, 1};
        tbl[2] = '{1'b1, 7'b0100001, 32'h00000020, 32'hDEADBE7F, 0,    2,    32'h000000A5, 1'b0, 1'b0, 1};
        tbl[3] = '{1'b1, 7'b1001000, 32'h0003FFFE, 32'h0,        0,    5,    32'h04030201, 1'b1, 1'b0, 4};
        tbl[4] = '{1'b1, 7'b1000000, 32'h00000040, 32'h0,        1000, 5,    32'h00000000, 1'b0, 1'b1, 0};
        tbl[5] = '{1'b1, 7'b1000001, 32'h00000040, 32'h0,        0,    1,    32'h00000000, 1'b0, 1'b1, 0};
        tbl[6] = '{1'b1, 7'b1100000, 32'h00000055, 32'h0,        3,    5,    32'h0000005C, 1'b1, 1'b0, 1};
        tbl[7] = '{1'b0, 7'b1001000, 32'h00000100, 32'h0,        0,    0,    32'h0000005C, 1'b0, 1'b0, 0};
        tbl[8] = '{1'b1, 7'b0010110, 32'h00000100, 32'h0,        0,    0,    32'h0000005C, 1'b0, 1'b0, 0};

        rst_n = 1'b0; valid_m = 1'b0; ctrl_m = '0; addr_m = '0; wdata_m = '0;
        ext_rdata = '0; ext_ack = 1'b0;
        #1;
        check("reset stall_m", 32'(stall_m), 32'd0);
        check("reset ext_req", 32'(ext_req), 32'd0);
        check("reset rdata_m", rdata_m, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 32'h0;

        for (int i = 0; i < 9; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].valid, tbl[i].ctrl, tbl[i].addr,
                          tbl[i].wdata, tbl[i].waits, 1'b0, tbl[i].exp_stall, tbl[i].exp_rdata,
                          tbl[i].exp_valid, tbl[i].exp_err, tbl[i].exp_beats);

        // Reset in the middle of a packed read, just after beat 1 completed.
        @(negedge clk);
        valid_m = 1'b1; ctrl_m = 7'b1001000; addr_m = 32'h200; wdata_m = '0; ext_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_access ext_req", 32'(ext_req), 32'd1);
        check("mid_access ext_addr", 32'(ext_addr), 32'h202);
        #1;
        rst_n = 1'b0; valid_m = 1'b0; ctrl_m = '0;
        #1;
        check("async_rst stall_m", 32'(stall_m), 32'd0);
        check("async_rst ext_req", 32'(ext_req), 32'd0);
        check("async_rst ext_addr", 32'(ext_addr), 32'd0);
        check("async_rst ext_sel_we", 32'({ext_sel, ext_we}), 32'd0);
        check("async_rst rdata_m", rdata_m, 32'd0);
        check("async_rst pulses", 32'({rdata_valid_m, err_m}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ext_ack = 1'b0;
        model_rdata = 32'h0;
        model(1'b1, 7'b1001000, 32'h200, 0, m_stall, m_rd, m_vld, m_er, m_beats);
        run_and_check("post_rst", 1'b1, 7'b1001000, 32'h200, 32'h0, 0, 1'b0,
                      m_stall, m_rd, m_vld, m_er, m_beats);

        for (int n = 0; n < 40; n++) begin
            c = 7'($urandom);
            if (c[0] && !c[6]) c[3] = 1'b0;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h0003FFFC + 32'($urandom_range(0, 3));
            v = ($urandom_range(0, 7) != 0);
            w = $urandom_range(0, 5);
            model(v, c, a, w, m_stall, m_rd, m_vld, m_er, m_beats);
            run_and_check($sformatf("rnd%0d", n), v, c, a, $urandom, w, 1'b1,
                          m_stall, m_rd, m_vld, m_er, m_beats);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
